// File: rtl/gouram_trace_serialiser.sv
// gouram_trace_serialiser: buffers 128-bit trace records in a small FIFO and
// drains them LSB-first as BEAT_WIDTH beats over a valid/ready stream.
// Records arriving while the buffer is full are dropped and counted.
module gouram_trace_serialiser #(
  parameter int RECORD_WIDTH   = 128,
  parameter int BEAT_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_valid_i,
  input  logic [RECORD_WIDTH-1:0]   trace_data_i,
  output logic                      beat_valid_o,
  input  logic                      beat_ready_i,
  output logic [BEAT_WIDTH-1:0]     beat_data_o,
  output logic                      beat_last_o,
  output logic [$clog2(DEPTH):0]    fill_level_o,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count_o,
  output logic                      overflow_o
);

  localparam int BEATS = RECORD_WIDTH / BEAT_WIDTH;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                          r_state, w_state_nxt;
  logic [RECORD_WIDTH-1:0]         r_mem [DEPTH];
  logic [PTR_W-1:0]                r_wptr, r_rptr;
  logic [CNT_W-1:0]                r_count, w_count_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [DROP_CNT_WIDTH-1:0]       r_drop;
  logic                            r_ovf;
  logic                            w_xfer, w_last_beat, w_pop, w_push;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] w_head;

  // Head record viewed as an array of beats, beat 0 in the low bits.
  assign w_head      = r_mem[r_rptr];
  assign w_last_beat = (r_idx == IDX_W'(BEATS - 1));
  assign w_xfer      = (r_state == S_SEND) && beat_ready_i;
  assign w_pop       = w_xfer && w_last_beat;
  // A full buffer still accepts a record when the head leaves on the same edge.
  assign w_push      = trace_valid_i && ((r_count < CNT_W'(DEPTH)) || w_pop);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Record storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= trace_data_i;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Drain FSM state and beat index within the head record.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) r_idx <= w_last_beat ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Next state: start sending once anything is buffered; after the final beat
  // keep sending without a bubble if another record is already waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_SEND;
      S_SEND:  if (w_pop && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stream outputs decode from registered state only; data is zero when idle.
  always_comb begin
    beat_valid_o = 1'b0;
    beat_data_o  = '0;
    beat_last_o  = 1'b0;
    if (r_state == S_SEND) begin
      beat_valid_o = 1'b1;
      beat_data_o  = w_head[r_idx];
      beat_last_o  = w_last_beat;
    end
  end

  // Drop accounting: one-cycle overflow pulse and a saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_ovf <= trace_valid_i && !w_push;
      if (trace_valid_i && !w_push && (r_drop != '1)) r_drop <= r_drop + DROP_CNT_WIDTH'(1);
    end
  end

  assign fill_level_o    = r_count;
  assign dropped_count_o = r_drop;
  assign overflow_o      = r_ovf;

endmodule
